// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared encodings for the pipelined MIPS core: ALUOp codes, ALU funct
//   codes, the zero-register specifier, and the packed control bundle that
//   travels down the pipeline.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  // ALUOp encodings from main control
  localparam logic [1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [1:0] ALUOP_MEM   = 2'b01;
  localparam logic [1:0] ALUOP_BR    = 2'b10;
  localparam logic [1:0] ALUOP_SLTI  = 2'b11;

  // Funct field constants
  localparam logic [5:0] FUNCT_ADD = 6'h04;
  localparam logic [5:0] FUNCT_SUB = 6'h14;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h2C;
  localparam logic [5:0] FUNCT_SLT = 6'h15;
  localparam logic [5:0] FUNCT_JR  = 6'h01;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Decoded control bundle; an all-zero value is a bubble.
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage : mips_pkg

`default_nettype wire

// File: rtl/id_ex_stage_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
//   Combinational load-use hazard compare. Flags when the instruction in EX
//   is a load whose destination (rt) is a non-zero register read by the
//   instruction currently in ID.
//   Ports:
//     ex_mem_read_i  - EX instruction is a load
//     ex_rt_i        - EX load destination register
//     id_rs_i/id_rt_i- ID source registers
//     hazard_o       - raw hazard (not qualified by hold)
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_use_detect
  import mips_pkg::*;
(
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  output logic       hazard_o
);

  assign hazard_o = ex_mem_read_i
                  & (ex_rt_i != REG_ZERO)
                  & ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));

endmodule : load_use_detect

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with load-use hazard detection. Captures decoded
//   controls, operands and register specifiers each cycle; writes a bubble
//   (zeroed controls) on flush or load-use; freezes on hold.
//   Optional macro: ID_EX_BUBBLE_CNT_EN builds a saturating bubble counter;
//   without it bubble_count is tied to zero.
//   Ports:
//     clk, rst (sync, active-low), hold, flush
//     id_*  - decoded controls, operands, specifiers from ID
//     ex_*  - registered copies presented to EX; ex_funct = ex_imm[5:0]
//     load_use_stall - combinational, holds PC and IF/ID this cycle
//     bubble_count   - number of bubbles written (saturating)
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          flush,
  input  logic          id_reg_write,
  input  logic          id_mem_to_reg,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_alu_src,
  input  logic          id_reg_dst,
  input  logic [1:0]    id_alu_op,
  input  logic [DW-1:0] id_rd1,
  input  logic [DW-1:0] id_rd2,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic [4:0]    id_rd,
  output logic          ex_reg_write,
  output logic          ex_mem_to_reg,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_alu_src,
  output logic          ex_reg_dst,
  output logic [1:0]    ex_alu_op,
  output logic [DW-1:0] ex_rd1,
  output logic [DW-1:0] ex_rd2,
  output logic [DW-1:0] ex_imm,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_rd,
  output logic [5:0]    ex_funct,
  output logic          load_use_stall,
  output logic [15:0]   bubble_count
);

  ctrl_t         ctrl_q,  ctrl_d;
  logic [DW-1:0] rd1_q,   rd1_d;
  logic [DW-1:0] rd2_q,   rd2_d;
  logic [DW-1:0] imm_q,   imm_d;
  logic [4:0]    rs_q,    rs_d;
  logic [4:0]    rt_q,    rt_d;
  logic [4:0]    rd_q,    rd_d;

  ctrl_t id_ctrl;
  logic  hazard;
  logic  bubble_we;

  assign id_ctrl = '{reg_write:  id_reg_write,
                     mem_to_reg: id_mem_to_reg,
                     mem_read:   id_mem_read,
                     mem_write:  id_mem_write,
                     alu_src:    id_alu_src,
                     reg_dst:    id_reg_dst,
                     alu_op:     id_alu_op};

  load_use_detect u_load_use_detect (
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rt_i       (rt_q),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .hazard_o      (hazard)
  );

  // While held, EX does not advance, so stalling IF/ID would be redundant;
  // the hazard is simply re-evaluated once hold drops.
  assign load_use_stall = hazard & ~hold;
  assign bubble_we      = ~hold & (flush | load_use_stall);

  always_comb begin
    ctrl_d = ctrl_q;
    rd1_d  = rd1_q;
    rd2_d  = rd2_q;
    imm_d  = imm_q;
    rs_d   = rs_q;
    rt_d   = rt_q;
    rd_d   = rd_q;
    if (!hold) begin
      // Data fields load even on a bubble: harmless with controls zeroed.
      ctrl_d = bubble_we ? CTRL_BUBBLE : id_ctrl;
      rd1_d  = id_rd1;
      rd2_d  = id_rd2;
      imm_d  = id_imm;
      rs_d   = id_rs;
      rt_d   = id_rt;
      rd_d   = id_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q <= CTRL_BUBBLE;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bubble_we && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bubble_count = cnt_q;
`else
  assign bubble_count = 16'd0;
`endif

  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_reg_dst    = ctrl_q.reg_dst;
  assign ex_alu_op     = ctrl_q.alu_op;
  assign ex_rd1        = rd1_q;
  assign ex_rd2        = rd2_q;
  assign ex_imm        = imm_q;
  assign ex_rs         = rs_q;
  assign ex_rt         = rt_q;
  assign ex_rd         = rd_q;
  assign ex_funct      = imm_q[5:0];

endmodule : id_ex_stage

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//   Self-checking bench for id_ex_stage: directed scenarios plus randomized
//   traffic checked against a behavioural model of the pipeline register.
//   Honors ID_EX_BUBBLE_CNT_EN the same way as the design.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, hold, flush;
  logic        id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write;
  logic        id_alu_src, id_reg_dst;
  logic [1:0]  id_alu_op;
  logic [31:0] id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
  logic        ex_alu_src, ex_reg_dst;
  logic [1:0]  ex_alu_op;
  logic [31:0] ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [5:0]  ex_funct;
  logic        load_use_stall;
  logic [15:0] bubble_count;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(32)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst), .ex_alu_op(ex_alu_op),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .load_use_stall(load_use_stall), .bubble_count(bubble_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: what EX should hold, plus the bubble tally.
  logic [7:0]  m_ctl;   // {rw, mtr, mr, mw, as, rdst, aluop[1:0]}
  logic [31:0] m_rd1, m_rd2, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  int          m_bubbles;

  function automatic logic model_stall();
    logic ex_is_load;
    ex_is_load = m_ctl[5];
    if (hold) return 1'b0;
    return ex_is_load && (m_rt != 5'd0) && (m_rt == id_rs || m_rt == id_rt);
  endfunction

  function automatic logic [15:0] model_count();
`ifdef ID_EX_BUBBLE_CNT_EN
    return (m_bubbles > 65535) ? 16'hFFFF : 16'(m_bubbles);
`else
    return 16'd0;
`endif
  endfunction

  // Evaluate the model for the coming rising edge using the current inputs.
  task automatic model_edge();
    logic st;
    st = model_stall();
    if (!rst) begin
      m_ctl = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
      m_rs = '0; m_rt = '0; m_rd = '0; m_bubbles = 0;
    end else if (!hold) begin
      if (flush || st) begin
        m_ctl = 8'h00;
        m_bubbles++;
      end else begin
        m_ctl = {id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
                 id_alu_src, id_reg_dst, id_alu_op};
      end
      m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm;
      m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
    end
  endtask

  task automatic chk_outs();
    chk("ex_ctl", {24'd0, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
                   ex_alu_src, ex_reg_dst, ex_alu_op}, {24'd0, m_ctl});
    chk("ex_rd1", ex_rd1, m_rd1);
    chk("ex_rd2", ex_rd2, m_rd2);
    chk("ex_imm", ex_imm, m_imm);
    chk("ex_funct", {26'd0, ex_funct}, {26'd0, m_imm[5:0]});
    chk("ex_regs", {17'd0, ex_rs, ex_rt, ex_rd}, {17'd0, m_rs, m_rt, m_rd});
    chk("bubble_count", {16'd0, bubble_count}, {16'd0, model_count()});
  endtask

  // Inputs are set around the falling edge; check the stall, clock, check EX.
  task automatic step();
    #1;
    chk("load_use_stall", {31'd0, load_use_stall}, {31'd0, model_stall()});
    model_edge();
    @(posedge clk);
    #1;
    chk_outs();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    hold = 0; flush = 0;
    id_reg_write = 0; id_mem_to_reg = 0; id_mem_read = 0; id_mem_write = 0;
    id_alu_src = 0; id_reg_dst = 0; id_alu_op = 2'b00;
    id_rd1 = 0; id_rd2 = 0; id_imm = 0; id_rs = 0; id_rt = 0; id_rd = 0;
  endtask

  task automatic rand_inputs();
    {id_reg_write, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_dst} = 5'($urandom);
    id_mem_read = ($urandom_range(0, 2) == 0);
    id_alu_op   = 2'($urandom);
    id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
    id_rs  = 5'($urandom_range(0, 3));
    id_rt  = 5'($urandom_range(0, 3));
    id_rd  = 5'($urandom);
  endtask

  logic [31:0] snap;

  initial begin
    m_ctl = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
    m_rs = '0; m_rt = '0; m_rd = '0; m_bubbles = 0;
    clear_inputs();
    rst = 0;
    @(negedge clk);

    // Reset with random inputs for two cycles
    repeat (2) begin
      rand_inputs(); hold = 1'($urandom); flush = 1'($urandom);
      step();
    end
    chk("rst_stall", {31'd0, load_use_stall}, 32'd0);
    chk("rst_count", {16'd0, bubble_count}, 32'd0);
    chk("rst_ctl", {30'd0, ex_alu_op}, 32'd0);

    // Pass-through
    rst = 1; clear_inputs();
    id_imm = 32'h24; id_rd1 = 32'h5; id_reg_write = 1;
    step();
    chk("pt_funct", {26'd0, ex_funct}, 32'h24);
    chk("pt_rd1", ex_rd1, 32'h5);
    chk("pt_rw", {31'd0, ex_reg_write}, 32'd1);

    // Load-use: load to r8, then a consumer of r8
    clear_inputs(); id_mem_read = 1; id_mem_to_reg = 1; id_reg_write = 1;
    id_alu_op = 2'b01; id_rt = 5'd8;
    step();
    clear_inputs(); id_rs = 5'd8; id_reg_write = 1; id_alu_op = 2'b00;
    #1;
    chk("lu_stall", {31'd0, load_use_stall}, 32'd1);
    step();
    chk("lu_bubble", {24'd0, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
                      ex_alu_src, ex_reg_dst, ex_alu_op}, 32'd0);
    // Replayed consumer must not stall again
    step();
    chk("lu_once", {31'd0, ex_reg_write}, 32'd1);

    // Load to r0 with a reader of r0: no hazard
    clear_inputs(); id_mem_read = 1; id_rt = 5'd0;
    step();
    clear_inputs(); id_rs = 5'd0;
    #1;
    chk("r0_nostall", {31'd0, load_use_stall}, 32'd0);
    step();

    // Flush a store
    clear_inputs(); flush = 1; id_mem_write = 1; id_alu_op = 2'b01;
    step();
    chk("fl_mw", {31'd0, ex_mem_write}, 32'd0);
    chk("fl_aluop", {30'd0, ex_alu_op}, 32'd0);

    // Load in EX, then hold + flush with a dependent ID for three cycles
    clear_inputs(); id_mem_read = 1; id_rt = 5'd3; id_rd1 = 32'hABCD;
    step();
    snap = {16'd0, bubble_count};
    repeat (3) begin
      rand_inputs(); id_rs = 5'd3; hold = 1; flush = 1;
      #1;
      chk("hold_stall", {31'd0, load_use_stall}, 32'd0);
      step();
      chk("hold_rd1", ex_rd1, 32'hABCD);
      chk("hold_cnt", {16'd0, bubble_count}, snap);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      hold  = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 60) != 0);
      step();
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    // Saturation: more flushes than the counter can represent
    rst = 1; clear_inputs(); flush = 1; id_rd1 = 32'h77;
    repeat (65540) begin
      model_edge();
      @(posedge clk);
    end
    #1;
    chk("sat_count", {16'd0, bubble_count}, 32'hFFFF);
    chk_outs();
    @(negedge clk);
    step();
    chk("sat_hold", {16'd0, bubble_count}, 32'hFFFF);
    rst = 0;
    step();
    chk("sat_rst", {16'd0, bubble_count}, 32'd0);
`else
    chk("cnt_off", {16'd0, bubble_count}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stuck run
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_id_ex_stage

`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register of the pipelined MIPS core, with integrated load-use hazard detection. It captures decoded control, operands and register specifiers from ID each cycle and presents them to EX, where `ex_alu_op` and `ex_funct` drive the ALU control stage. It inserts a bubble on a load-use hazard or a flush, and freezes on an external hold.

## Interface
- `DW`, 32, datapath width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-low reset.
- `hold` input 1: freeze all EX outputs; the downstream stage is stalled.
- `flush` input 1: squash the instruction entering EX (taken branch / jr).
- `id_reg_write`, `id_mem_to_reg`, `id_mem_read`, `id_mem_write`, `id_alu_src`, `id_reg_dst` input 1 each: decoded controls.
- `id_alu_op` input 2: ALUOp from main control.
- `id_rd1`, `id_rd2` input DW: register file read data.
- `id_imm` input DW: sign-extended immediate; bits [5:0] are the funct field.
- `id_rs`, `id_rt`, `id_rd` input 5: register specifiers.
- `ex_*` output, same widths as the matching `id_*` inputs: registered copies.
- `ex_funct` output 6: `ex_imm[5:0]`.
- `load_use_stall` output 1, combinational: PC and IF/ID must hold this cycle.
- `bubble_count` output 16: see Configuration.

## Operation
- Hazard: `load_use_stall` = `ex_mem_read` & (`ex_rt` != 0) & ((`ex_rt` == `id_rs`) | (`ex_rt` == `id_rt`)).
  - A stall is not raised when `hold` is high; the hazard is re-evaluated after release.
- Register update priority each rising edge, highest first:
  1. `rst`==0: all `ex_*` outputs cleared to 0.
  2. `hold`: all `ex_*` outputs keep their value. `hold` beats `flush` and the hazard bubble.
  3. `flush` or `load_use_stall`: bubble. All six control bits and `ex_alu_op` become 0. Data and specifier fields are loaded normally; they are don't-care but deterministic.
  4. Otherwise: every `ex_*` output is loaded from the matching `id_*` input.
- A bubble carries `ex_alu_op`=00 with a live funct. This is harmless because all write and memory enables are 0.
- State: one implicit state per cycle, Valid or Bubble, encoded by the zeroed controls. No explicit FSM beyond the register and the optional counter.

## Timing
- Latency is 1 cycle from ID inputs to EX outputs.
- `load_use_stall` is combinational in the same cycle. It creates exactly one bubble per load-use pair, because the bubble clears `ex_mem_read` in the next cycle.
- Reset mid-operation takes effect on the next edge regardless of `hold` or `flush`.
- After reset, `load_use_stall`=0 because `ex_mem_read`=0.
- Back-to-back loads with dependencies: each load yields at most one bubble.

## Configuration
- Macro `ID_EX_BUBBLE_CNT_EN`.
- Defined: `bubble_count` increments by 1 on every edge where a bubble is written (`flush` | `load_use_stall`, with `hold`=0). It saturates at 16'hFFFF and is cleared by reset.
- Undefined: `bubble_count` is tied to 0 and no counter logic is built.

## Structure
- Shared package `mips_pkg` holds:
  - ALUOp encodings: `ALUOP_RTYPE`=2'b00, `ALUOP_MEM`=2'b01, `ALUOP_BR`=2'b10, `ALUOP_SLTI`=2'b11.
  - Funct constants: add 6'h04, sub 6'h14, and 6'h24, or 6'h2C, slt 6'h15, jr 6'h01.
  - `REG_ZERO`=5'd0.
- Sub-module `load_use_detect` holds the combinational hazard compare. The top level holds the register and the counter.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with random inputs -> all `ex_*`=0, `load_use_stall`=0, `bubble_count`=0.
- Pass-through: `id_alu_op`=00, `id_imm`=32'h24, `id_rd1`=32'h5, `id_reg_write`=1 -> next cycle `ex_funct`=6'h24, `ex_rd1`=5, `ex_reg_write`=1.
- Load-use: load with `ex_rt`=8 in EX and `id_rs`=8 -> `load_use_stall`=1, next cycle all controls 0, `bubble_count`=1 (macro on). `ex_rt`=0 with `id_rs`=0 -> no stall.
- Flush: `flush`=1 with `id_mem_write`=1 -> next cycle `ex_mem_write`=0, `ex_alu_op`=00.
- Hold priority: `hold`=1 with `flush`=1 and new inputs for 3 cycles -> outputs unchanged, `load_use_stall`=0, counter unchanged.
- Saturation (macro on): force 65536 consecutive flushes -> `bubble_count` stays at 16'hFFFF. Macro off -> `bubble_count` is always 0.
